// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC multiplier scheduler.
// Holds the FSM state enum, operand/result widths and an ID-width helper.
package cordic_sched_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
// Ports: req (requests), ptr (search start) -> gnt (one-hot), idx, any_req.
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any_req
);

    int j;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                gnt[j]  = 1'b1;
                idx     = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/cordic_mul_scheduler.sv
// Round-robin scheduler sharing one sequential CORDIC multiplier among N_REQ requesters.
// Ports: req_* (per-requester valid/ready/operands), mul_* (core start/done/operands/product),
//        rsp_* (response channel with id/product/error), busy, jobs_done.
module cordic_mul_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int MUL_ITERS = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_x,
    input  logic [OP_W*N_REQ-1:0] req_z,
    output logic                  mul_start,
    output logic [OP_W-1:0]       mul_x,
    output logic [OP_W-1:0]       mul_z,
    input  logic [RES_W-1:0]      mul_y,
    input  logic                  mul_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [RES_W-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           jobs_done
);

    // A timeout shorter than a compliant core's latency would abort every
    // job, so the effective limit never drops below MUL_ITERS+2.
    localparam int TMO = (TIMEOUT > MUL_ITERS + 1) ? TIMEOUT : MUL_ITERS + 2;
    localparam int TW  = $clog2(TMO + 1);

    state_e            state;
    state_e            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gidx;
    logic [N_REQ-1:0]  gnt;
    logic              any_req;
    logic [TW-1:0]     timer;
    logic              timed_out;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .idx     (gidx),
        .any_req (any_req)
    );

    assign timed_out = (timer == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready = gnt;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mul_start = 1'b1;
                if (mul_done || timed_out) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // start stays low here so the core always sees a clear cycle
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            mul_x     <= '0;
            mul_z     <= '0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            timer     <= '0;
            jobs_done <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        mul_x  <= req_x[gidx*OP_W +: OP_W];
                        mul_z  <= req_z[gidx*OP_W +: OP_W];
                        rsp_id <= gidx;
                        rr_ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        timer  <= '0;
                    end
                end
                RUN: begin
                    timer <= timer + 1'b1;
                    if (mul_done) begin
                        rsp_y   <= mul_y;
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_y   <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        jobs_done <= jobs_done + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_mul_scheduler.md
Name: cordic_mul_scheduler

Overview:
- Round-robin scheduler that shares one sequential CORDIC multiplier core among N_REQ requesters.
- Accepts signed 8-bit operand pairs over per-requester valid/ready.
- Sequences the core's level-held start / done protocol, including the mandatory start-low clear cycle.
- Returns each 16-bit product with the requester ID on a single response channel; a timeout guards against a hung core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, response ID width; must equal clog2(N_REQ).
- MUL_ITERS, 16, core iteration count; done is expected MUL_ITERS+1 cycles after start rises.
- TIMEOUT, 32, maximum RUN cycles before the job is aborted with an error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept pulse.
- req_x  in  8*N_REQ  signed multiplicand, slice i belongs to requester i.
- req_z  in  8*N_REQ  signed multiplier, slice i belongs to requester i.
- mul_start  out  1  core start, held high for the whole job.
- mul_x  out  8  latched x to core.
- mul_z  out  8  latched z to core.
- mul_y  in  16  core product.
- mul_done  in  1  core done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index of the response.
- rsp_y  out  16  product; 0 on error.
- rsp_err  out  1  1 = timed out.
- busy  out  1  high whenever state != IDLE.
- jobs_done  out  16  count of completed responses, wraps at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - mul_start, req_ready, rsp_valid, rsp_err, busy = 0.
  - mul_x, mul_z, rsp_y, rsp_id, jobs_done, timer = 0.
  - Reset mid-job abandons the job with no response. Because mul_start drops, the core clears itself.
- States: IDLE, RUN, RESP.
- IDLE:
  - mul_start=0.
  - If any req_valid bit is set, grant the first set bit searching from rr_ptr upward, modulo N_REQ.
  - req_ready[g]=1 combinationally in that same cycle; the handshake completes there.
  - On the edge: latch mul_x/mul_z from slice g, rsp_id=g, rr_ptr=(g+1) mod N_REQ, timer=0, state goes to RUN.
  - No valid bits: stay in IDLE; rr_ptr is unchanged.
- RUN:
  - mul_start=1; req_ready all 0; timer increments each cycle.
  - mul_done=1: capture rsp_y=mul_y, rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_y=0, rsp_err=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - mul_start=0, which guarantees at least one start-low edge so the core returns to its initial state.
  - rsp_valid=1; rsp_id, rsp_y, rsp_err are stable while valid and not ready.
  - On rsp_ready: jobs_done+=1, go to IDLE.
  - Requests are never accepted in RESP.
- Latency, with accept in cycle T and a compliant core:
  - mul_start is high from T+1.
  - mul_done is high in T+MUL_ITERS+1 (T+17).
  - rsp_valid is high from T+18.
  - Minimum issue interval is 19 cycles, with rsp_ready held high.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,...; no requester waits more than N_REQ-1 jobs.
- req_valid may drop without acceptance; no stickiness is required. Operands are sampled only in the accept cycle.
- Width rules: rsp_y is passed through unmodified from mul_y. Neither scaling nor sign manipulation happens in this block.

Decomposition:
- Package cordic_sched_pkg holds:
  - state enum (IDLE, RUN, RESP);
  - OP_W=8 and RES_W=16 constants;
  - function computing ID_W from N_REQ.
- One sub-module, rr_arbiter:
  - inputs: N_REQ request vector, rr_ptr;
  - outputs: one-hot grant, encoded index, any_req.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Uses a stub core that asserts done MUL_ITERS+1 cycles after start rises and returns x*z.
- Single job: req0 x=5, z=64 -> req_ready[0] at T; rsp_valid at T+18 with rsp_id=0, rsp_y=320, rsp_err=0; jobs_done=1.
- Contention: all four valid with x=i+1, z=-3 -> responses in order id 0,1,2,3 with rsp_y=-3,-6,-9,-12 (0xFFFD, 0xFFFA, 0xFFF7, 0xFFF4); issue interval 19 cycles.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises -> rsp_y, rsp_id stable; mul_start=0 throughout; no new req_ready until the accept.
- Timeout: stub never asserts done -> after 32 RUN cycles, rsp_err=1, rsp_y=0, mul_start drops; the next job completes normally.
- Reset mid-RUN: pulse rst_n low in cycle T+8 -> mul_start, busy, rsp_valid immediately 0; rr_ptr=0; a job submitted afterwards yields a correct response.
- Pointer fairness: req2 only, then req0 and req2 together -> grant req0 next (rr_ptr=3 wraps to 0), then req2.
